// File: rtl/two_demux_pkg.sv
// Shared types and constants for the two-channel TDM mux/demux pair.
// The select polarity constants must match the mux side of the link.
package two_demux_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_ERRW  = 8;

    localparam logic SEL_CH0 = 1'b1;
    localparam logic SEL_CH1 = 1'b0;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        CH0  = 2'd1,
        CH1  = 2'd2
    } state_t;

endpackage

// File: rtl/two_demux_tdm_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
// Count updates on the edge that samples inc_i; it never wraps.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/two_demux_tdm.sv
// Two-channel TDM demux: locks on sof, steers words to y0/y1 with 1-cycle latency, no back-pressure.
// TWO_DEMUX_PAIR_EN: hold the ch0 word and release y0/y1 together when its ch1 partner arrives.
module two_demux_tdm
    import two_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERRW  = DEF_ERRW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_sof,
    input  logic             clr,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             y0_valid,
    output logic             y1_valid,
    output logic             sel,
    output logic             locked,
    output logic             sync_err,
    output logic [ERRW-1:0]  err_count
);

    state_t           state_q, state_d;
    logic             route0, route1, resync;
    logic [WIDTH-1:0] y0_q, y1_q;
    logic             y0_vld_q, y1_vld_q, sync_err_q;

    always_comb begin
        state_d = state_q;
        route0  = 1'b0;
        route1  = 1'b0;
        resync  = 1'b0;
        if (clr) begin
            state_d = HUNT;
        end else if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (din_sof) begin
                        route0  = 1'b1;
                        state_d = CH1;
                    end
                end
                CH1: begin
                    if (din_sof) begin
                        route0 = 1'b1;
                        resync = 1'b1;
                    end else begin
                        route1  = 1'b1;
                        state_d = CH0;
                    end
                end
                CH0: begin
                    route0  = 1'b1;
                    state_d = CH1;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_err_q <= resync;
        end
    end

`ifdef TWO_DEMUX_PAIR_EN
    // A stale held word is never released: after resync/clr the next ch0 overwrites it first.
    logic [WIDTH-1:0] hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            y0_vld_q <= 1'b0;
            y1_vld_q <= 1'b0;
        end else begin
            y0_vld_q <= route1;
            y1_vld_q <= route1;
            if (route0) begin
                hold_q <= din;
            end
            if (route1) begin
                y0_q <= hold_q;
                y1_q <= din;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_q     <= '0;
            y1_q     <= '0;
            y0_vld_q <= 1'b0;
            y1_vld_q <= 1'b0;
        end else begin
            y0_vld_q <= route0;
            y1_vld_q <= route1;
            if (route0) begin
                y0_q <= din;
            end
            if (route1) begin
                y1_q <= din;
            end
        end
    end
`endif

    sat_counter #(
        .W(ERRW)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .inc_i (resync),
        .cnt_o (err_count)
    );

    assign y0       = y0_q;
    assign y1       = y1_q;
    assign y0_valid = y0_vld_q;
    assign y1_valid = y1_vld_q;
    assign sync_err = sync_err_q;
    assign sel      = (state_q == CH1) ? SEL_CH1 : SEL_CH0;
    assign locked   = (state_q != HUNT);

endmodule
